// File: rtl/multi_port_main_memory_interface_pkg.sv
// Shared message codes, FSM state encoding and geometry helpers for the
// main memory interface family.
package mem_msg_pkg;

  localparam int unsigned NO_REQ   = 0;
  localparam int unsigned R_REQ    = 1;
  localparam int unsigned WB_REQ   = 2;
  localparam int unsigned MEM_RESP = 3;
  localparam int unsigned MEM_ACK  = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RESPOND = 2'd3
  } state_t;

  function automatic int unsigned beats_of(input int unsigned offset_bits);
    return 32'd1 << offset_bits;
  endfunction

  function automatic int unsigned line_width_of(input int unsigned data_width,
                                                input int unsigned offset_bits);
    return data_width * beats_of(offset_bits);
  endfunction

  // Pointer width never collapses to zero so a single-port build stays legal.
  function automatic int unsigned ptr_width_of(input int unsigned num_ports);
    return (num_ports > 1) ? $clog2(num_ports) : 1;
  endfunction

endpackage

// File: rtl/multi_port_main_memory_interface_rr_arbiter.sv
// Round-robin arbiter: combinational grant search starting at the pointer,
// with a registered pointer that advances past each accepted grant.
module rr_arbiter
  import mem_msg_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned PTR_W     = ptr_width_of(NUM_PORTS)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_PORTS-1:0] request,
  input  logic [NUM_PORTS-1:0] mask,
  input  logic                 advance,
  output logic [NUM_PORTS-1:0] grant,
  output logic [PTR_W-1:0]     grant_index,
  output logic                 grant_valid
);

  logic [PTR_W-1:0]     rr_ptr;
  logic [PTR_W-1:0]     cand;
  logic [NUM_PORTS-1:0] eligible;

  assign eligible = request & ~mask;

  // First eligible port at or after the pointer, wrapping modulo NUM_PORTS.
  always_comb begin
    grant       = '0;
    grant_index = '0;
    grant_valid = 1'b0;
    cand        = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      cand = PTR_W'((32'(rr_ptr) + i) % NUM_PORTS);
      if (!grant_valid && eligible[cand]) begin
        grant_valid = 1'b1;
        grant_index = cand;
      end
    end
    if (grant_valid) grant[grant_index] = 1'b1;
  end

  // Pointer moves to the port after the one just granted.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
    end else if (advance && grant_valid) begin
      rr_ptr <= PTR_W'((32'(grant_index) + 32'd1) % NUM_PORTS);
    end
  end

endmodule

// File: rtl/multi_port_main_memory_interface.sv
// Multi-port main memory interface: arbitrates cache-hierarchy ports,
// splits each line into word beats toward memory and reassembles reads.
module multi_port_main_memory_interface
  import mem_msg_pkg::*;
#(
  parameter int unsigned NUM_PORTS     = 2,
  parameter int unsigned OFFSET_BITS   = 2,
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned ADDRESS_WIDTH = 64,
  parameter int unsigned MSG_BITS      = 4,
  localparam int unsigned BEATS        = beats_of(OFFSET_BITS),
  localparam int unsigned LINE_WIDTH   = line_width_of(DATA_WIDTH, OFFSET_BITS),
  localparam int unsigned PTR_W        = ptr_width_of(NUM_PORTS)
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [NUM_PORTS*MSG_BITS-1:0]      cache2intf_msg,
  input  logic [NUM_PORTS*ADDRESS_WIDTH-1:0] cache2intf_address,
  input  logic [NUM_PORTS*LINE_WIDTH-1:0]    cache2intf_data,
  output logic [NUM_PORTS*MSG_BITS-1:0]      intf2cache_msg,
  output logic [NUM_PORTS*ADDRESS_WIDTH-1:0] intf2cache_address,
  output logic [NUM_PORTS*LINE_WIDTH-1:0]    intf2cache_data,
  output logic [MSG_BITS-1:0]                intf2mem_msg,
  output logic [ADDRESS_WIDTH-1:0]           intf2mem_address,
  output logic [DATA_WIDTH-1:0]              intf2mem_data,
  input  logic [MSG_BITS-1:0]                mem2intf_msg,
  input  logic [ADDRESS_WIDTH-1:0]           mem2intf_address,
  input  logic [DATA_WIDTH-1:0]              mem2intf_data,
  output logic                               busy
);

  state_t                   state, state_n;
  logic [OFFSET_BITS-1:0]   beat, beat_n;
  logic [PTR_W-1:0]         gnt_idx, idx_n;
  logic                     op_write, op_n;
  logic [ADDRESS_WIDTH-1:0] line_addr, addr_n;
  logic [LINE_WIDTH-1:0]    wr_line, wl_n;
  logic [LINE_WIDTH-1:0]    rd_line, rd_n;
  logic                     just_served;

  logic [NUM_PORTS-1:0]     request, mask, grant;
  logic [PTR_W-1:0]         grant_index;
  logic                     grant_valid;
  logic [MSG_BITS-1:0]      sel_msg;
  logic [ADDRESS_WIDTH-1:0] sel_addr;
  logic [LINE_WIDTH-1:0]    sel_line;
  logic                     beat_done;

  logic [MSG_BITS-1:0]                mem_msg_n;
  logic [ADDRESS_WIDTH-1:0]           mem_addr_n;
  logic [DATA_WIDTH-1:0]              mem_data_n;
  logic [NUM_PORTS*MSG_BITS-1:0]      c_msg_n;
  logic [NUM_PORTS*ADDRESS_WIDTH-1:0] c_addr_n;
  logic [NUM_PORTS*LINE_WIDTH-1:0]    c_data_n;

  // Memory echoes the beat address but only one beat is ever outstanding.
  logic unused_mem_address;
  assign unused_mem_address = ^mem2intf_address;

  // Only read and writeback codes count as requests.
  always_comb begin
    request = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      request[p] = (cache2intf_msg[p*MSG_BITS +: MSG_BITS] == MSG_BITS'(R_REQ)) ||
                   (cache2intf_msg[p*MSG_BITS +: MSG_BITS] == MSG_BITS'(WB_REQ));
    end
  end

  // Keep the port served last from being re-granted in the guard cycle.
  always_comb begin
    mask = '0;
    if (just_served) mask[gnt_idx] = 1'b1;
  end

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .PTR_W     (PTR_W)
  ) u_arbiter (
    .clock       (clock),
    .reset       (reset),
    .request     (request),
    .mask        (mask),
    .advance     (state == IDLE),
    .grant       (grant),
    .grant_index (grant_index),
    .grant_valid (grant_valid)
  );

  // One-hot AND-OR mux of the granted port's request fields.
  always_comb begin
    sel_msg  = '0;
    sel_addr = '0;
    sel_line = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (grant[p]) begin
        sel_msg  = sel_msg  | cache2intf_msg[p*MSG_BITS +: MSG_BITS];
        sel_addr = sel_addr | cache2intf_address[p*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        sel_line = sel_line | cache2intf_data[p*LINE_WIDTH +: LINE_WIDTH];
      end
    end
  end

  // A beat completes only on the response code matching the current op.
  assign beat_done = op_write ? (mem2intf_msg == MSG_BITS'(MEM_ACK))
                              : (mem2intf_msg == MSG_BITS'(MEM_RESP));

  // Next state and next transaction context.
  always_comb begin
    state_n = state;
    beat_n  = beat;
    idx_n   = gnt_idx;
    op_n    = op_write;
    addr_n  = line_addr;
    wl_n    = wr_line;
    rd_n    = rd_line;
    case (state)
      IDLE: begin
        if (grant_valid) begin
          state_n = ISSUE;
          beat_n  = '0;
          idx_n   = grant_index;
          op_n    = (sel_msg == MSG_BITS'(WB_REQ));
          addr_n  = sel_addr;
          wl_n    = sel_line;
          rd_n    = '0;
        end
      end
      ISSUE: state_n = WAIT;
      WAIT: begin
        if (beat_done) begin
          if (!op_write) rd_n[beat*DATA_WIDTH +: DATA_WIDTH] = mem2intf_data;
          if (beat == OFFSET_BITS'(BEATS - 1)) begin
            state_n = RESPOND;
          end else begin
            state_n = ISSUE;
            beat_n  = beat + 1'b1;
          end
        end
      end
      RESPOND: begin
        state_n = IDLE;
        beat_n  = '0;
      end
      default: state_n = IDLE;
    endcase
  end

  // Output values for the coming cycle, derived from the next state so the
  // registered outputs line up with the state they belong to.
  always_comb begin
    mem_msg_n  = MSG_BITS'(NO_REQ);
    mem_addr_n = '0;
    mem_data_n = '0;
    c_msg_n    = '0;
    c_addr_n   = '0;
    c_data_n   = '0;
    if (state_n == ISSUE) begin
      mem_msg_n  = op_n ? MSG_BITS'(WB_REQ) : MSG_BITS'(R_REQ);
      mem_addr_n = {addr_n[ADDRESS_WIDTH-1:OFFSET_BITS], beat_n};
      mem_data_n = op_n ? wl_n[beat_n*DATA_WIDTH +: DATA_WIDTH] : '0;
    end
    if (state_n == RESPOND) begin
      c_msg_n[idx_n*MSG_BITS +: MSG_BITS]           = op_n ? MSG_BITS'(MEM_ACK)
                                                           : MSG_BITS'(MEM_RESP);
      c_addr_n[idx_n*ADDRESS_WIDTH +: ADDRESS_WIDTH] = addr_n;
      c_data_n[idx_n*LINE_WIDTH +: LINE_WIDTH]       = op_n ? '0 : rd_n;
    end
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // Transaction context, guard flag and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      beat               <= '0;
      gnt_idx            <= '0;
      op_write           <= 1'b0;
      line_addr          <= '0;
      wr_line            <= '0;
      rd_line            <= '0;
      just_served        <= 1'b0;
      intf2mem_msg       <= MSG_BITS'(NO_REQ);
      intf2mem_address   <= '0;
      intf2mem_data      <= '0;
      intf2cache_msg     <= '0;
      intf2cache_address <= '0;
      intf2cache_data    <= '0;
      busy               <= 1'b0;
    end else begin
      beat               <= beat_n;
      gnt_idx            <= idx_n;
      op_write           <= op_n;
      line_addr          <= addr_n;
      wr_line            <= wl_n;
      rd_line            <= rd_n;
      just_served        <= (state == RESPOND);
      intf2mem_msg       <= mem_msg_n;
      intf2mem_address   <= mem_addr_n;
      intf2mem_data      <= mem_data_n;
      intf2cache_msg     <= c_msg_n;
      intf2cache_address <= c_addr_n;
      intf2cache_data    <= c_data_n;
      busy               <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_multi_port_main_memory_interface.sv
// Directed bench: a two-port 4-beat instance and a one-port 8-beat instance,
// with the memory side driven cycle by cycle from the stimulus sequence.
module tb_multi_port_main_memory_interface;

  localparam logic [3:0] NO_REQ   = 4'd0;
  localparam logic [3:0] R_REQ    = 4'd1;
  localparam logic [3:0] WB_REQ   = 4'd2;
  localparam logic [3:0] MEM_RESP = 4'd3;
  localparam logic [3:0] MEM_ACK  = 4'd4;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Instance A: 2 ports, 4 beats per line
  logic         a_rst;
  logic [7:0]   a_c_msg;
  logic [127:0] a_c_addr;
  logic [511:0] a_c_data;
  logic [7:0]   a_i_msg;
  logic [127:0] a_i_addr;
  logic [511:0] a_i_data;
  logic [3:0]   a_m_msg;
  logic [63:0]  a_m_addr, a_m_data;
  logic [3:0]   a_mr_msg;
  logic [63:0]  a_mr_addr, a_mr_data;
  logic         a_busy;

  // Instance B: 1 port, 8 beats per line
  logic         b_rst;
  logic [3:0]   b_c_msg;
  logic [63:0]  b_c_addr;
  logic [511:0] b_c_data;
  logic [3:0]   b_i_msg;
  logic [63:0]  b_i_addr;
  logic [511:0] b_i_data;
  logic [3:0]   b_m_msg;
  logic [63:0]  b_m_addr, b_m_data;
  logic [3:0]   b_mr_msg;
  logic [63:0]  b_mr_addr, b_mr_data;
  logic         b_busy;

  multi_port_main_memory_interface #(
    .NUM_PORTS(2), .OFFSET_BITS(2), .DATA_WIDTH(64), .ADDRESS_WIDTH(64), .MSG_BITS(4)
  ) dut_a (
    .clock(clock), .reset(a_rst),
    .cache2intf_msg(a_c_msg), .cache2intf_address(a_c_addr), .cache2intf_data(a_c_data),
    .intf2cache_msg(a_i_msg), .intf2cache_address(a_i_addr), .intf2cache_data(a_i_data),
    .intf2mem_msg(a_m_msg), .intf2mem_address(a_m_addr), .intf2mem_data(a_m_data),
    .mem2intf_msg(a_mr_msg), .mem2intf_address(a_mr_addr), .mem2intf_data(a_mr_data),
    .busy(a_busy)
  );

  multi_port_main_memory_interface #(
    .NUM_PORTS(1), .OFFSET_BITS(3), .DATA_WIDTH(64), .ADDRESS_WIDTH(64), .MSG_BITS(4)
  ) dut_b (
    .clock(clock), .reset(b_rst),
    .cache2intf_msg(b_c_msg), .cache2intf_address(b_c_addr), .cache2intf_data(b_c_data),
    .intf2cache_msg(b_i_msg), .intf2cache_address(b_i_addr), .intf2cache_data(b_i_data),
    .intf2mem_msg(b_m_msg), .intf2mem_address(b_m_addr), .intf2mem_data(b_m_data),
    .mem2intf_msg(b_mr_msg), .mem2intf_address(b_mr_addr), .mem2intf_data(b_mr_data),
    .busy(b_busy)
  );

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_mem(input bit sel, input logic [3:0] m, input logic [63:0] a,
                         input logic [63:0] d);
    if (sel) begin
      b_mr_msg = m; b_mr_addr = a; b_mr_data = d;
    end else begin
      a_mr_msg = m; a_mr_addr = a; a_mr_data = d;
    end
  endtask

  // Called at the cycle a beat must be issued; returns at the cycle the next
  // beat (or the cache response) is due. Memory answers lat cycles later.
  task automatic mem_beat(input bit sel, input int lat, input logic [3:0] emsg,
                          input logic [63:0] eaddr, input logic [63:0] edata,
                          input logic [3:0] rmsg, input logic [63:0] rdata,
                          input bit spur, input string tag);
    logic [3:0] om;
    om = sel ? b_m_msg : a_m_msg;
    check({tag, "_msg"}, om, emsg);
    check({tag, "_addr"}, sel ? b_m_addr : a_m_addr, eaddr);
    check({tag, "_data"}, sel ? b_m_data : a_m_data, edata);
    for (int i = 1; i < lat; i++) begin
      @(negedge clock);
      if (spur && i == 1) set_mem(sel, MEM_ACK, eaddr, 64'hBAD0BAD0);
      else                set_mem(sel, NO_REQ, 64'h0, 64'h0);
    end
    @(negedge clock);
    set_mem(sel, rmsg, eaddr, rdata);
    om = sel ? b_m_msg : a_m_msg;
    check({tag, "_wait_noreq"}, om, NO_REQ);
    @(negedge clock);
    set_mem(sel, NO_REQ, 64'h0, 64'h0);
  endtask

  initial begin
    logic [511:0] line_b;
    longint t0;

    a_rst = 1'b0; a_c_msg = '0; a_c_addr = '0; a_c_data = '0;
    a_mr_msg = '0; a_mr_addr = '0; a_mr_data = '0;
    b_rst = 1'b0; b_c_msg = '0; b_c_addr = '0; b_c_data = '0;
    b_mr_msg = '0; b_mr_addr = '0; b_mr_data = '0;
    repeat (2) @(negedge clock);

    // Reset state
    check("rst_a_cmsg", a_i_msg, 0);
    check("rst_a_caddr", a_i_addr, 0);
    check("rst_a_cdata", a_i_data, 0);
    check("rst_a_mmsg", a_m_msg, NO_REQ);
    check("rst_a_maddr", a_m_addr, 0);
    check("rst_a_busy", a_busy, 0);
    check("rst_b_cmsg", b_i_msg, 0);
    check("rst_b_mmsg", b_m_msg, NO_REQ);
    a_rst = 1'b1;
    b_rst = 1'b1;
    @(negedge clock);

    // Single read on port0, L=1: response at cycle 9
    a_c_msg[3:0] = R_REQ;
    a_c_addr[63:0] = 64'h100;
    check("t1_busy_c0", a_busy, 0);
    @(negedge clock);
    check("t1_busy_c1", a_busy, 1);
    for (int k = 0; k < 4; k++)
      mem_beat(0, 1, R_REQ, 64'h100 + 64'(k), 64'h0, MEM_RESP, 64'hA0 + 64'(k), 0, "t1_beat");
    check("t1_resp_msg", a_i_msg[3:0], MEM_RESP);
    check("t1_resp_addr", a_i_addr[63:0], 64'h100);
    check("t1_resp_line", a_i_data[255:0], {64'hA3, 64'hA2, 64'hA1, 64'hA0});
    check("t1_p1_msg", a_i_msg[7:4], NO_REQ);
    check("t1_p1_addr", a_i_addr[127:64], 0);
    check("t1_p1_data", a_i_data[511:256], 0);
    check("t1_busy_respond", a_busy, 1);
    // Request held through the guard cycle
    @(negedge clock);
    check("t1_resp_one_cycle", a_i_msg, 0);
    check("t1_guard_busy", a_busy, 0);
    @(negedge clock);
    check("t1_guard_no_regrant", a_m_msg, NO_REQ);
    check("t1_guard_busy2", a_busy, 0);

    // Pointer now at port1: simultaneous requests, port1 writeback wins
    a_c_addr[63:0] = 64'h200;
    a_c_msg[7:4] = WB_REQ;
    a_c_addr[127:64] = 64'h40;
    a_c_data[511:256] = {64'hD3, 64'hD2, 64'hD1, 64'hD0};
    @(negedge clock);
    for (int k = 0; k < 4; k++)
      mem_beat(0, 1, WB_REQ, 64'h40 + 64'(k), 64'hD0 + 64'(k), MEM_ACK, 64'h0, 0, "t2_wb");
    check("t2_ack_msg", a_i_msg[7:4], MEM_ACK);
    check("t2_ack_addr", a_i_addr[127:64], 64'h40);
    check("t2_ack_data", a_i_data[511:256], 0);
    check("t2_p0_waiting", a_i_msg[3:0], NO_REQ);
    a_c_msg[7:4] = NO_REQ;
    @(negedge clock);
    check("t2_ack_one_cycle", a_i_msg, 0);
    check("t2_gap_noreq", a_m_msg, NO_REQ);
    @(negedge clock);
    for (int k = 0; k < 4; k++)
      mem_beat(0, 1, R_REQ, 64'h200 + 64'(k), 64'h0, MEM_RESP, 64'hB0 + 64'(k), 0, "t2_rd");
    check("t2_rd_msg", a_i_msg[3:0], MEM_RESP);
    check("t2_rd_addr", a_i_addr[63:0], 64'h200);
    check("t2_rd_line", a_i_data[255:0], {64'hB3, 64'hB2, 64'hB1, 64'hB0});
    a_c_msg[3:0] = NO_REQ;
    @(negedge clock);

    // From reset, both request: port0 then port1
    a_rst = 1'b0;
    @(negedge clock);
    a_rst = 1'b1;
    a_c_msg = {R_REQ, R_REQ};
    a_c_addr = {64'h380, 64'h300};
    @(negedge clock);
    for (int k = 0; k < 4; k++)
      mem_beat(0, 1, R_REQ, 64'h300 + 64'(k), 64'h0, MEM_RESP, 64'hC0 + 64'(k), 0, "t3_p0");
    check("t3_p0_msg", a_i_msg[3:0], MEM_RESP);
    check("t3_p0_line", a_i_data[255:0], {64'hC3, 64'hC2, 64'hC1, 64'hC0});
    check("t3_p1_still_waiting", a_i_msg[7:4], NO_REQ);
    a_c_msg[3:0] = NO_REQ;
    @(negedge clock);
    check("t3_gap_noreq", a_m_msg, NO_REQ);
    @(negedge clock);
    for (int k = 0; k < 4; k++)
      mem_beat(0, 1, R_REQ, 64'h380 + 64'(k), 64'h0, MEM_RESP, 64'hE0 + 64'(k), 0, "t3_p1");
    check("t3_p1_msg", a_i_msg[7:4], MEM_RESP);
    check("t3_p1_addr", a_i_addr[127:64], 64'h380);
    check("t3_p1_line", a_i_data[511:256], {64'hE3, 64'hE2, 64'hE1, 64'hE0});
    check("t3_p0_idle", a_i_msg[3:0], NO_REQ);
    a_c_msg[7:4] = NO_REQ;
    @(negedge clock);

    // Reset during WAIT of beat 2 abandons the transaction
    a_c_msg[3:0] = R_REQ;
    a_c_addr[63:0] = 64'h600;
    @(negedge clock);
    for (int k = 0; k < 2; k++)
      mem_beat(0, 1, R_REQ, 64'h600 + 64'(k), 64'h0, MEM_RESP, 64'h11 + 64'(k), 0, "t4_pre");
    check("t4_beat2_addr", a_m_addr, 64'h602);
    @(negedge clock);
    check("t4_busy_before", a_busy, 1);
    a_rst = 1'b0;
    #1;
    check("t4_rst_busy", a_busy, 0);
    check("t4_rst_mmsg", a_m_msg, NO_REQ);
    check("t4_rst_cmsg", a_i_msg, 0);
    check("t4_rst_caddr", a_i_addr, 0);
    @(negedge clock);
    a_rst = 1'b1;
    a_c_msg = {R_REQ, NO_REQ};
    a_c_addr = {64'h700, 64'h0};
    @(negedge clock);
    for (int k = 0; k < 4; k++)
      mem_beat(0, 1, R_REQ, 64'h700 + 64'(k), 64'h0, MEM_RESP, 64'h21 + 64'(k), 0, "t4_post");
    check("t4_p1_msg", a_i_msg[7:4], MEM_RESP);
    check("t4_p1_line", a_i_data[511:256], {64'h24, 64'h23, 64'h22, 64'h21});
    check("t4_p0_no_resp", a_i_msg[3:0], NO_REQ);
    a_c_msg = '0;

    // Single port, 8 beats, L=5 with spurious MEM_ACK during each wait
    @(negedge clock);
    b_c_msg = R_REQ;
    b_c_addr = 64'h800;
    t0 = longint'($time);
    @(negedge clock);
    for (int k = 0; k < 8; k++)
      mem_beat(1, 5, R_REQ, 64'h800 + 64'(k), 64'h0, MEM_RESP, 64'h1000 + 64'(k), 1, "t5_beat");
    check("t5_latency", (longint'($time) - t0) / 10, 49);
    line_b = {64'h1007, 64'h1006, 64'h1005, 64'h1004,
              64'h1003, 64'h1002, 64'h1001, 64'h1000};
    check("t5_resp_msg", b_i_msg, MEM_RESP);
    check("t5_resp_addr", b_i_addr, 64'h800);
    check("t5_resp_line", b_i_data, line_b);
    @(negedge clock);
    check("t5_resp_one_cycle", b_i_msg, NO_REQ);
    @(negedge clock);
    check("t5_guard_no_regrant", b_m_msg, NO_REQ);
    check("t5_guard_busy", b_busy, 0);
    @(negedge clock);
    check("t5_regrant_after_guard", b_m_msg, R_REQ);
    check("t5_regrant_addr", b_m_addr, 64'h800);
    b_c_msg = NO_REQ;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
